// File: rtl/decode_pkg.sv
// Shared constants for the RV32I ID stage: opcodes, instruction-format codes,
// the bubble encoding and the immediate builder.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] IT_R = 3'd0;
    localparam logic [2:0] IT_I = 3'd1;
    localparam logic [2:0] IT_S = 3'd2;
    localparam logic [2:0] IT_B = 3'd3;
    localparam logic [2:0] IT_U = 3'd4;
    localparam logic [2:0] IT_J = 3'd5;

    // A bubble is identified downstream by outValid=0, opcode=0, regdest=0.
    localparam logic [6:0] NOP_OPCODE  = 7'b0000000;
    localparam logic [4:0] NOP_REGDEST = 5'd0;

    // Sign-extended immediate for the given instruction format.
    function automatic logic [31:0] build_imm(input logic [31:0] i, input logic [2:0] it);
        logic [31:0] v;
        case (it)
            IT_I:    v = {{20{i[31]}}, i[31:20]};
            IT_S:    v = {{20{i[31]}}, i[31:25], i[11:7]};
            IT_B:    v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IT_U:    v = {i[31:12], 12'h000};
            IT_J:    v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero.
// Optional macro DECODE_WB_BYPASS_EN: a read of the register being written
// this cycle returns the write data instead of the stored value.
module regfile_2r1w
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem_r [NREGS];

    // Storage: cleared on reset, written on the rising edge; writes to x0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                mem_r[k] <= {XLEN{1'b0}};
            end
        end else if (wen && (waddr != {AW{1'b0}})) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port A: x0 reads zero, optional same-cycle write forwarding.
    always_comb begin
        if (raddr_a == {AW{1'b0}}) begin
            rdata_a = {XLEN{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
        end else if (wen && (raddr_a == waddr)) begin
            rdata_a = wdata;
`endif
        end else begin
            rdata_a = mem_r[raddr_a];
        end
    end

    // Read port B: same behaviour as port A.
    always_comb begin
        if (raddr_b == {AW{1'b0}}) begin
            rdata_b = {XLEN{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
        end else if (wen && (raddr_b == waddr)) begin
            rdata_b = wdata;
`endif
        end else begin
            rdata_b = mem_r[raddr_b];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decodes the IF/ID instruction, reads the register file,
// builds the immediate, detects hazards and registers the ID/EX entry.
// Optional macro DECODE_WB_BYPASS_EN: forward WB data to same-cycle reads;
// without it the stage stalls one extra cycle on a WB/read collision.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pcIn,
    input  logic            flush,
    input  logic            wbEn,
    input  logic [4:0]      wbAddr,
    input  logic [XLEN-1:0] wbData,
    output logic            stall,
    output logic            outValid,
    output logic [XLEN-1:0] regdataA,
    output logic [XLEN-1:0] regdataB,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] immediate,
    output logic [2:0]      itype,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      regdest,
    output logic            iOrR,
    output logic            illegal
);

    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [6:0]      opc_s;
    logic            legal_s;
    logic [2:0]      itype_s;
    logic            use_rs1_s;
    logic            use_rs2_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      regdest_s;
    logic            iorr_s;
    logic [31:0]     imm_s;
    logic [XLEN-1:0] rdata_a_s;
    logic [XLEN-1:0] rdata_b_s;
    logic            load_use_s;
    logic            wb_hit_s;
    logic            accept_s;

    assign rs1_s = instr[19:15];
    assign rs2_s = instr[24:20];
    assign opc_s = instr[6:0];

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (5)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (rs1_s),
        .raddr_b (rs2_s),
        .rdata_a (rdata_a_s),
        .rdata_b (rdata_b_s),
        .wen     (wbEn),
        .waddr   (wbAddr),
        .wdata   (wbData)
    );

    // Opcode classification into instruction format and legality.
    always_comb begin
        legal_s = 1'b1;
        itype_s = IT_R;
        case (opc_s)
            OP_R:                     itype_s = IT_R;
            OP_IMM, OP_LOAD, OP_JALR: itype_s = IT_I;
            OP_STORE:                 itype_s = IT_S;
            OP_BRANCH:                itype_s = IT_B;
            OP_LUI, OP_AUIPC:         itype_s = IT_U;
            OP_JAL:                   itype_s = IT_J;
            default: begin
                legal_s = 1'b0;
                itype_s = IT_R;
            end
        endcase
    end

    // Field extraction and source-register usage per format.
    always_comb begin
        use_rs1_s = legal_s && (itype_s != IT_U) && (itype_s != IT_J);
        use_rs2_s = legal_s && ((itype_s == IT_R) || (itype_s == IT_S) || (itype_s == IT_B));
        imm_s     = build_imm(instr, itype_s);
        iorr_s    = !((itype_s == IT_R) || (itype_s == IT_B));
        if ((itype_s == IT_U) || (itype_s == IT_J)) begin
            funct3_s = 3'd0;
        end else begin
            funct3_s = instr[14:12];
        end
        // Shift-immediates carry the arithmetic/logical select in funct7.
        if ((itype_s == IT_R) ||
            ((opc_s == OP_IMM) && ((instr[14:12] == 3'd1) || (instr[14:12] == 3'd5)))) begin
            funct7_s = instr[31:25];
        end else begin
            funct7_s = 7'd0;
        end
        if ((itype_s == IT_S) || (itype_s == IT_B)) begin
            regdest_s = 5'd0;
        end else begin
            regdest_s = instr[11:7];
        end
    end

    // Hazard detection: load-use against the ID/EX entry, plus WB collision when not forwarding.
    always_comb begin
        load_use_s = outValid && (opcode == OP_LOAD) && (regdest != 5'd0) &&
                     ((use_rs1_s && (rs1_s == regdest)) || (use_rs2_s && (rs2_s == regdest)));
`ifdef DECODE_WB_BYPASS_EN
        wb_hit_s = 1'b0;
`else
        wb_hit_s = wbEn && (wbAddr != 5'd0) &&
                   ((use_rs1_s && (rs1_s == wbAddr)) || (use_rs2_s && (rs2_s == wbAddr)));
`endif
        // A flush kills the consumer, and reset must never leave the front end frozen.
        stall    = rst_n && !flush && inValid && (load_use_s || wb_hit_s);
        accept_s = inValid && legal_s && !flush && !stall;
    end

    // ID/EX pipeline register: load on accept, otherwise insert a bubble holding the data fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid  <= 1'b0;
            regdataA  <= {XLEN{1'b0}};
            regdataB  <= {XLEN{1'b0}};
            PC        <= {XLEN{1'b0}};
            immediate <= {XLEN{1'b0}};
            itype     <= 3'd0;
            opcode    <= NOP_OPCODE;
            funct3    <= 3'd0;
            funct7    <= 7'd0;
            regdest   <= NOP_REGDEST;
            iOrR      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            illegal <= inValid && !legal_s && !flush;
            if (accept_s) begin
                outValid  <= 1'b1;
                regdataA  <= rdata_a_s;
                regdataB  <= rdata_b_s;
                PC        <= pcIn;
                immediate <= imm_s[XLEN-1:0];
                itype     <= itype_s;
                opcode    <= opc_s;
                funct3    <= funct3_s;
                funct7    <= funct7_s;
                regdest   <= regdest_s;
                iOrR      <= iorr_s;
            end else begin
                outValid <= 1'b0;
                opcode   <= NOP_OPCODE;
                regdest  <= NOP_REGDEST;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table of instruction vectors plus
// hand-written multi-cycle sequences, expected results queued as a scoreboard.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic [31:0] instr;
    logic [31:0] pcIn;
    logic        flush;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        stall;
    logic        outValid;
    logic [31:0] regdataA;
    logic [31:0] regdataB;
    logic [31:0] PC;
    logic [31:0] immediate;
    logic [2:0]  itype;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  regdest;
    logic        iOrR;
    logic        illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .instr     (instr),
        .pcIn      (pcIn),
        .flush     (flush),
        .wbEn      (wbEn),
        .wbAddr    (wbAddr),
        .wbData    (wbData),
        .stall     (stall),
        .outValid  (outValid),
        .regdataA  (regdataA),
        .regdataB  (regdataB),
        .PC        (PC),
        .immediate (immediate),
        .itype     (itype),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .regdest   (regdest),
        .iOrR      (iOrR),
        .illegal   (illegal)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [2:0]  it;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        iorr;
        logic        ill;
        logic        full;
        logic        chkdata;
        logic        chkimm;
    } vec_t;

    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mkv(input logic [31:0] ins, pc, a, b, imm,
                                 input logic [2:0] it, f3, input logic [6:0] f7,
                                 input logic [4:0] rd, input logic io, cd, ci);
        vec_t v;
        v.ins = ins; v.pc = pc; v.valid = 1'b1; v.a = a; v.b = b; v.imm = imm;
        v.it = it; v.opc = ins[6:0]; v.f3 = f3; v.f7 = f7; v.rd = rd; v.iorr = io;
        v.ill = 1'b0; v.full = 1'b1; v.chkdata = cd; v.chkimm = ci;
        return v;
    endfunction

    function automatic vec_t bubble(input logic ill);
        vec_t v;
        v = mkv(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 3'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        v.valid = 1'b0; v.opc = 7'd0; v.ill = ill; v.full = 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    task automatic cmp_rec(input vec_t e);
        chk("outValid", {31'd0, outValid}, {31'd0, e.valid});
        chk("opcode",   {25'd0, opcode},   {25'd0, e.opc});
        chk("regdest",  {27'd0, regdest},  {27'd0, e.rd});
        chk("illegal",  {31'd0, illegal},  {31'd0, e.ill});
        if (e.full) begin
            chk("PC",     PC,               e.pc);
            chk("itype",  {29'd0, itype},   {29'd0, e.it});
            chk("funct3", {29'd0, funct3},  {29'd0, e.f3});
            chk("funct7", {25'd0, funct7},  {25'd0, e.f7});
            chk("iOrR",   {31'd0, iOrR},    {31'd0, e.iorr});
        end
        if (e.chkimm) chk("immediate", immediate, e.imm);
        if (e.chkdata) begin
            chk("regdataA", regdataA, e.a);
            chk("regdataB", regdataB, e.b);
        end
    endtask

    // Drive an instruction into IF/ID and queue what the ID/EX register must show next.
    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v, input vec_t e);
        instr = ins; pcIn = pc; inValid = v;
        exp_q.push_back(e);
    endtask

    // Advance one edge and compare the oldest queued expectation.
    task automatic step();
        vec_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard: actual empty required entry");
        end else begin
            e = exp_q.pop_front();
            cmp_rec(e);
        end
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wbEn = 1'b1; wbAddr = a; wbData = d;
        @(posedge clk);
        #1;
        wbEn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[11];
        vec_t e;
        tbl[0]  = mkv(32'h002081B3, 32'h100, 32'd5, 32'd4, 32'h0,        3'd0, 3'd0, 7'h00, 5'd3,  1'b0, 1'b1, 1'b0);
        tbl[1]  = mkv(32'hFFF08213, 32'h104, 32'd5, 32'd0, 32'hFFFFFFFF, 3'd1, 3'd0, 7'h00, 5'd4,  1'b1, 1'b1, 1'b1);
        tbl[2]  = mkv(32'h0020A423, 32'h108, 32'd5, 32'd4, 32'h8,        3'd2, 3'd2, 7'h00, 5'd0,  1'b1, 1'b1, 1'b1);
        tbl[3]  = mkv(32'hFE208EE3, 32'h10C, 32'd5, 32'd4, 32'hFFFFFFFC, 3'd3, 3'd0, 7'h00, 5'd0,  1'b0, 1'b1, 1'b1);
        tbl[4]  = mkv(32'h123454B7, 32'h110, 32'd0, 32'd0, 32'h12345000, 3'd4, 3'd0, 7'h00, 5'd9,  1'b1, 1'b0, 1'b1);
        tbl[5]  = mkv(32'h0080056F, 32'h114, 32'd0, 32'd0, 32'h8,        3'd5, 3'd0, 7'h00, 5'd10, 1'b1, 1'b0, 1'b1);
        tbl[6]  = mkv(32'h4030D593, 32'h118, 32'd5, 32'd0, 32'h403,      3'd1, 3'd5, 7'h20, 5'd11, 1'b1, 1'b1, 1'b1);
        tbl[7]  = mkv(32'h40208633, 32'h11C, 32'd5, 32'd4, 32'h0,        3'd0, 3'd0, 7'h20, 5'd12, 1'b0, 1'b1, 1'b0);
        tbl[8]  = mkv(32'h004086E7, 32'h120, 32'd5, 32'd0, 32'h4,        3'd1, 3'd0, 7'h00, 5'd13, 1'b1, 1'b1, 1'b1);
        tbl[9]  = mkv(32'hFFFFF717, 32'h124, 32'd0, 32'd0, 32'hFFFFF000, 3'd4, 3'd0, 7'h00, 5'd14, 1'b1, 1'b0, 1'b1);
        tbl[10] = mkv(32'hFF817793, 32'h128, 32'd4, 32'd0, 32'hFFFFFFF8, 3'd1, 3'd7, 7'h00, 5'd15, 1'b1, 1'b1, 1'b1);

        rst_n = 1'b0; inValid = 1'b0; instr = 32'h0; pcIn = 32'h0; flush = 1'b0;
        wbEn = 1'b0; wbAddr = 5'd0; wbData = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst outValid",  {31'd0, outValid}, 32'd0);
        chk("rst illegal",   {31'd0, illegal},  32'd0);
        chk("rst PC",        PC,                32'd0);
        chk("rst immediate", immediate,         32'd0);
        chk("rst regdataA",  regdataA,          32'd0);
        chk("rst stall",     {31'd0, stall},    32'd0);
        rst_n = 1'b1;

        wb(5'd1, 32'd5);
        wb(5'd2, 32'd4);

        // Table of single-instruction decodes issued back to back.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].ins, tbl[i].pc, 1'b1, tbl[i]);
            step();
        end

        // Load-use: lw x5 then add x6,x5,x2 -> one stall, bubble, then add.
        drive(32'h0000A283, 32'h200, 1'b1,
              mkv(32'h0000A283, 32'h200, 32'd5, 32'd0, 32'h0, 3'd1, 3'd2, 7'h00, 5'd5, 1'b1, 1'b1, 1'b1));
        step();
        drive(32'h00228333, 32'h204, 1'b1, bubble(1'b0));
        #1;
        chk("loaduse stall", {31'd0, stall}, 32'd1);
        step();
        chk("loaduse stall released", {31'd0, stall}, 32'd0);
        e = mkv(32'h00228333, 32'h204, 32'd0, 32'd4, 32'h0, 3'd0, 3'd0, 7'h00, 5'd6, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(e);
        step();

        // Flush with a load-use pending: no stall, bubble.
        drive(32'h0000A283, 32'h300, 1'b1,
              mkv(32'h0000A283, 32'h300, 32'd5, 32'd0, 32'h0, 3'd1, 3'd2, 7'h00, 5'd5, 1'b1, 1'b1, 1'b1));
        step();
        flush = 1'b1;
        drive(32'h00228333, 32'h304, 1'b1, bubble(1'b0));
        #1;
        chk("flush stall", {31'd0, stall}, 32'd0);
        step();
        flush = 1'b0;
        drive(32'h00228333, 32'h304, 1'b0, bubble(1'b0));
        step();

        // Writes to x0 are dropped.
        wb(5'd0, 32'h0000DEAD);
        drive(32'h000003B3, 32'h400, 1'b1,
              mkv(32'h000003B3, 32'h400, 32'd0, 32'd0, 32'h0, 3'd0, 3'd0, 7'h00, 5'd7, 1'b0, 1'b1, 1'b0));
        step();

        // WB write to x1 in the same cycle as add x8,x1,x1.
        wbEn = 1'b1; wbAddr = 5'd1; wbData = 32'd9;
        e = mkv(32'h00108433, 32'h500, 32'd9, 32'd9, 32'h0, 3'd0, 3'd0, 7'h00, 5'd8, 1'b0, 1'b1, 1'b0);
`ifdef DECODE_WB_BYPASS_EN
        drive(32'h00108433, 32'h500, 1'b1, e);
        #1;
        chk("wb bypass stall", {31'd0, stall}, 32'd0);
        step();
        wbEn = 1'b0;
`else
        drive(32'h00108433, 32'h500, 1'b1, bubble(1'b0));
        #1;
        chk("wb collision stall", {31'd0, stall}, 32'd1);
        step();
        wbEn = 1'b0;
        #1;
        chk("wb collision released", {31'd0, stall}, 32'd0);
        exp_q.push_back(e);
        step();
`endif

        // Illegal opcode: one-cycle pulse and a bubble.
        drive(32'h0000007F, 32'h600, 1'b1, bubble(1'b1));
        step();
        drive(32'h0000007F, 32'h604, 1'b0, bubble(1'b0));
        step();

        // Reset asserted while stalled.
        drive(32'h0000A283, 32'h700, 1'b1,
              mkv(32'h0000A283, 32'h700, 32'd9, 32'd0, 32'h0, 3'd1, 3'd2, 7'h00, 5'd5, 1'b1, 1'b1, 1'b1));
        step();
        instr = 32'h00228333; pcIn = 32'h704;
        #1;
        chk("pre-reset stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst stall",     {31'd0, stall},    32'd0);
        chk("midrst outValid",  {31'd0, outValid}, 32'd0);
        chk("midrst regdataA",  regdataA,          32'd0);
        chk("midrst regdataB",  regdataB,          32'd0);
        chk("midrst PC",        PC,                32'd0);
        chk("midrst immediate", immediate,         32'd0);
        chk("midrst regdest",   {27'd0, regdest},  32'd0);
        chk("midrst opcode",    {25'd0, opcode},   32'd0);
        chk("midrst iOrR",      {31'd0, iOrR},     32'd0);
        inValid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Register file is cleared by reset.
        drive(32'h002081B3, 32'h800, 1'b1,
              mkv(32'h002081B3, 32'h800, 32'd0, 32'd0, 32'h0, 3'd0, 3'd0, 7'h00, 5'd3, 1'b0, 1'b1, 1'b0));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
